vec_req_arbiter: RTL and testbench
==================================

# vec_req_arbiter

Parametrised N-way request arbiter that merges `N_REQ` decoupled requestor channels onto one registered memory-side channel. It generalises the fixed four-channel, priority-muxed requestor merge with a real valid/ready handshake on both sides, selectable fixed-priority or round-robin arbitration, multi-beat burst locking and a one-entry output register. It sits between a vector of client ports and a single memory port.

## Interface
Parameters:
- `N_REQ`, 4: number of requestor channels; at least 2.
- `DATA_W`, 8: payload width per beat.
- `RR_MODE`, 0: 0 = fixed priority, highest index wins; 1 = round robin.
- `CHOSEN_W`, derived: max(1, clog2(`N_REQ`)).

Ports:
- `clk`  in  1  the single clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `io_req_valid`  in  `N_REQ`  per-channel beat valid.
- `io_req_last`  in  `N_REQ`  per-channel last-beat-of-burst flag, qualified by valid.
- `io_req_bits`  in  `N_REQ*DATA_W`  payloads; channel i occupies bits [i*DATA_W +: DATA_W].
- `io_req_ready`  out  `N_REQ`  per-channel accept; at most one bit set in any cycle.
- `io_mem_valid`  out  1  output register holds a beat.
- `io_mem_ready`  in  1  downstream accepts.
- `io_mem_bits`  out  `DATA_W`  buffered payload.
- `io_mem_last`  out  1  buffered last flag.
- `io_mem_chosen`  out  `CHOSEN_W`  index of the channel that supplied the buffered beat.

## Operation
- State: output register (valid, bits, last, chosen), RR pointer `ptr` (`CHOSEN_W` bits), `locked` flag, `lock_idx`.
- `can_accept` = !`io_mem_valid` || `io_mem_ready` (combinational path from `io_mem_ready` to `io_req_ready` is required).
- Grant selection, when not locked:
  - Fixed mode: highest-index channel with valid set.
  - RR mode: first channel with valid set, searching `ptr`, `ptr+1`, … with wrap modulo `N_REQ`.
- When locked: only `lock_idx` is eligible; all other readies stay 0 even if `lock_idx` has valid low (a bubble).
- `io_req_ready[g]` = `can_accept` && grant valid; every other bit is 0.
- A beat is accepted on channel g when `io_req_valid[g]` && `io_req_ready[g]`. On acceptance the output register loads bits/last/g and sets valid.
- If `io_mem_valid` && `io_mem_ready` and no beat is accepted, valid clears.
- Lock/unlock on acceptance:
  - last=0: `locked`<=1, `lock_idx`<=g.
  - last=1: `locked`<=0.
- RR pointer advances only when a beat with last=1 is accepted on g: `ptr` <= g+1, wrapping from `N_REQ`-1 to 0. Fixed mode ignores `ptr`.
- Single-beat requests, with last=1 on every beat, give plain per-beat arbitration.
- Payload is passed unmodified; no width conversion.

## Timing
- Reset values: `io_mem_valid`=0, `io_mem_bits`=0, `io_mem_last`=0, `io_mem_chosen`=0, `ptr`=0, `locked`=0. `io_req_ready`=0 during reset.
- Latency: a beat accepted in cycle t appears on `io_mem_*` in cycle t+1.
- Throughput: one beat per cycle while `io_mem_ready`=1.
- Backpressure: while the register is full and `io_mem_ready`=0, all readies are 0 and the register holds stable.
- Simultaneous drain and accept in the same cycle: the new beat replaces the old one, and valid stays 1.
- A downstream must not see `io_mem_*` change while `io_mem_valid`=1 and `io_mem_ready`=0.
- Reset mid-operation: the buffered beat is dropped, the lock is cleared and `ptr` returns to 0 on the next edge.
- A requestor dropping valid mid-burst keeps the lock; the arbiter waits indefinitely.

## Test plan
- Reset then idle: after reset, `io_mem_valid`=0, `io_req_ready`=0000, `io_mem_chosen`=0. Asserting all valids with `io_mem_ready`=1 gives ready only on a single channel within the same cycle.
- Fixed mode, N_REQ=4: valid=1111 with last=1 and bits 0x10..0x13. Expected: ch3 granted every cycle; `io_mem_bits`=0x13 and `io_mem_chosen`=3 from the next cycle on; ch0–2 starve.
- RR mode: valid=1111 with last=1 held for 8 cycles. Expected: `io_mem_chosen` sequence 0,1,2,3,0,1,2,3 on cycles 1..8.
- Burst lock, RR mode: ch1 sends 3 beats (last=0,0,1) while ch2 is valid. Expected: ch2 ready=0 for all three beats; ch1 drops valid for one cycle mid-burst and nothing is granted; ch2 is granted on the cycle after ch1's last beat is accepted; `ptr`=2.
- Backpressure: `io_mem_ready`=0 for 5 cycles with ch0 valid. Expected: `io_mem_bits` is held with exactly one beat buffered; readies are 0. When ready rises, the next beat is accepted the same cycle and valid stays 1.
- Reset mid-burst: `reset` is asserted one cycle after ch2 sends last=0. Expected: next cycle `io_mem_valid`=0 and `locked`=0; after release, ch0 wins in RR mode because `ptr`=0.

Source files
------------

// File: rtl/vec_req_arbiter.sv
// N-way valid/ready request arbiter with fixed-priority or round-robin selection,
// burst locking on multi-beat requests and a one-entry registered memory-side output.
module vec_req_arbiter #(
  parameter int N_REQ    = 4,
  parameter int DATA_W   = 8,
  parameter int RR_MODE  = 0,
  parameter int CHOSEN_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_REQ-1:0]          io_req_valid,
  input  logic [N_REQ-1:0]          io_req_last,
  input  logic [N_REQ*DATA_W-1:0]   io_req_bits,
  output logic [N_REQ-1:0]          io_req_ready,
  output logic                      io_mem_valid,
  input  logic                      io_mem_ready,
  output logic [DATA_W-1:0]         io_mem_bits,
  output logic                      io_mem_last,
  output logic [CHOSEN_W-1:0]       io_mem_chosen
);

  logic                valid_q, valid_d;
  logic [DATA_W-1:0]   bits_q, bits_d;
  logic                last_q, last_d;
  logic [CHOSEN_W-1:0] chosen_q, chosen_d;
  logic [CHOSEN_W-1:0] ptr_q, ptr_d;
  logic                locked_q, locked_d;
  logic [CHOSEN_W-1:0] lock_idx_q, lock_idx_d;

  logic                grant_valid;
  logic [CHOSEN_W-1:0] grant_idx;
  logic                can_accept;
  logic                accept;
  logic [DATA_W-1:0]   sel_bits;
  logic                sel_last;
  int                  cand;

  // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    if (locked_q) begin
      // A locked burst owns the channel even through bubbles on its own valid.
      grant_idx   = lock_idx_q;
      grant_valid = io_req_valid[lock_idx_q];
    end else if (RR_MODE != 0) begin
      // Descending scan so the candidate closest to ptr is assigned last and wins.
      for (int k = N_REQ - 1; k >= 0; k--) begin
        cand = (int'(ptr_q) + k) % N_REQ;
        if (io_req_valid[cand]) begin
          grant_valid = 1'b1;
          grant_idx   = CHOSEN_W'(cand);
        end
      end
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (io_req_valid[i]) begin
          grant_valid = 1'b1;
          grant_idx   = CHOSEN_W'(i);
        end
      end
    end
  end

  assign can_accept = !valid_q || io_mem_ready;
  assign accept     = !reset && can_accept && grant_valid;
  assign sel_bits   = io_req_bits[grant_idx*DATA_W +: DATA_W];
  assign sel_last   = io_req_last[grant_idx];

  always_comb begin
    io_req_ready = '0;
    if (accept) io_req_ready[grant_idx] = 1'b1;
  end

  always_comb begin
    valid_d    = valid_q;
    bits_d     = bits_q;
    last_d     = last_q;
    chosen_d   = chosen_q;
    ptr_d      = ptr_q;
    locked_d   = locked_q;
    lock_idx_d = lock_idx_q;
    if (accept) begin
      valid_d  = 1'b1;
      bits_d   = sel_bits;
      last_d   = sel_last;
      chosen_d = grant_idx;
      locked_d = !sel_last;
      if (!sel_last) lock_idx_d = grant_idx;
      if (sel_last)
        ptr_d = (grant_idx == CHOSEN_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end else if (valid_q && io_mem_ready) begin
      valid_d = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q    <= 1'b0;
      bits_q     <= '0;
      last_q     <= 1'b0;
      chosen_q   <= '0;
      ptr_q      <= '0;
      locked_q   <= 1'b0;
      lock_idx_q <= '0;
    end else begin
      valid_q    <= valid_d;
      bits_q     <= bits_d;
      last_q     <= last_d;
      chosen_q   <= chosen_d;
      ptr_q      <= ptr_d;
      locked_q   <= locked_d;
      lock_idx_q <= lock_idx_d;
    end
  end

  assign io_mem_valid  = valid_q;
  assign io_mem_bits   = bits_q;
  assign io_mem_last   = last_q;
  assign io_mem_chosen = chosen_q;

endmodule

// File: tb/tb_vec_req_arbiter.sv
// Drives a fixed-priority and a round-robin arbiter with shared stimulus and checks
// both against a behavioural model every cycle, plus hand-computed directed expectations.
module tb_vec_req_arbiter;
  localparam int N = 4;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] req_valid, req_last;
  logic [N*W-1:0] req_bits;
  logic         mem_ready;

  logic [N-1:0] rdy_fp, rdy_rr;
  logic         mv_fp, mv_rr, ml_fp, ml_rr;
  logic [W-1:0] mb_fp, mb_rr;
  logic [1:0]   mc_fp, mc_rr;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  vec_req_arbiter #(.N_REQ(N), .DATA_W(W), .RR_MODE(0)) dut_fp (
    .clk(clk), .reset(reset), .io_req_valid(req_valid), .io_req_last(req_last),
    .io_req_bits(req_bits), .io_req_ready(rdy_fp), .io_mem_valid(mv_fp),
    .io_mem_ready(mem_ready), .io_mem_bits(mb_fp), .io_mem_last(ml_fp),
    .io_mem_chosen(mc_fp));

  vec_req_arbiter #(.N_REQ(N), .DATA_W(W), .RR_MODE(1)) dut_rr (
    .clk(clk), .reset(reset), .io_req_valid(req_valid), .io_req_last(req_last),
    .io_req_bits(req_bits), .io_req_ready(rdy_rr), .io_mem_valid(mv_rr),
    .io_mem_ready(mem_ready), .io_mem_bits(mb_rr), .io_mem_last(ml_rr),
    .io_mem_chosen(mc_rr));

  // Behavioural model state, one per arbitration mode (0 = fixed, 1 = round robin).
  typedef struct {
    bit       v;
    bit [7:0] bits;
    bit       last;
    int       chosen;
    int       ptr;
    bit       locked;
    int       lock_idx;
  } mstate_t;

  mstate_t m[2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Which channel may be accepted this cycle, built from the priority order of candidates.
  function automatic logic [N-1:0] exp_ready(input int mode);
    int order[$];
    logic [N-1:0] r = '0;
    if (reset) return '0;
    if (m[mode].v && !mem_ready) return '0;
    if (m[mode].locked) order.push_back(m[mode].lock_idx);
    else
      for (int k = 0; k < N; k++)
        order.push_back(mode == 1 ? (m[mode].ptr + k) % N : N - 1 - k);
    foreach (order[i]) begin
      if (req_valid[order[i]]) begin
        r[order[i]] = 1'b1;
        break;
      end
    end
    return r;
  endfunction

  task automatic model_step(input int mode);
    logic [N-1:0] r;
    int g;
    r = exp_ready(mode);
    if (reset) begin
      m[mode] = '{default: 0};
    end else if (r != '0) begin
      g = 0;
      for (int i = 0; i < N; i++) if (r[i]) g = i;
      m[mode].v      = 1'b1;
      m[mode].bits   = req_bits[g*W +: W];
      m[mode].last   = req_last[g];
      m[mode].chosen = g;
      if (req_last[g]) begin
        m[mode].locked = 1'b0;
        m[mode].ptr    = (g + 1) % N;
      end else begin
        m[mode].locked   = 1'b1;
        m[mode].lock_idx = g;
      end
    end else if (m[mode].v && mem_ready) begin
      m[mode].v = 1'b0;
    end
  endtask

  always @(posedge clk) begin
    model_step(0);
    model_step(1);
  end

  task automatic compare_inst(input int mode, input logic [N-1:0] rdy, input logic v,
                              input logic [W-1:0] b, input logic l, input logic [1:0] c);
    check($sformatf("m%0d_ready", mode), 32'(rdy), 32'(exp_ready(mode)));
    check($sformatf("m%0d_onehot", mode), 32'($countones(rdy) <= 1), 32'd1);
    check($sformatf("m%0d_valid", mode), 32'(v), 32'(m[mode].v));
    check($sformatf("m%0d_bits", mode), 32'(b), 32'(m[mode].bits));
    check($sformatf("m%0d_last", mode), 32'(l), 32'(m[mode].last));
    check($sformatf("m%0d_chosen", mode), 32'(c), 32'(m[mode].chosen));
  endtask

  initial begin
    forever begin
      @(negedge clk);
      #2;
      compare_inst(0, rdy_fp, mv_fp, mb_fp, ml_fp, mc_fp);
      compare_inst(1, rdy_rr, mv_rr, mb_rr, ml_rr, mc_rr);
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    m[0] = '{default: 0};
    m[1] = '{default: 0};
    reset = 1'b1; req_valid = '0; req_last = '0; req_bits = '0; mem_ready = 1'b1;
    repeat (3) tick();

    // Reset then idle.
    tick(); reset = 1'b0; #3;
    check("idle_mv_fp", 32'(mv_fp), 32'd0);
    check("idle_rdy_fp", 32'(rdy_fp), 32'd0);
    check("idle_chosen_rr", 32'(mc_rr), 32'd0);
    check("idle_mv_rr", 32'(mv_rr), 32'd0);

    // All four valid, single-beat requests.
    tick(); req_valid = 4'hF; req_last = 4'hF; req_bits = 32'h13121110; #3;
    check("all_rdy_fp", 32'(rdy_fp), 32'h8);
    check("all_rdy_rr", 32'(rdy_rr), 32'h1);
    for (int j = 1; j <= 8; j++) begin
      tick(); #3;
      check("fp_bits", 32'(mb_fp), 32'h13);
      check("fp_chosen", 32'(mc_fp), 32'd3);
      check("fp_rdy", 32'(rdy_fp), 32'h8);
      check("rr_chosen_seq", 32'(mc_rr), 32'((j - 1) % 4));
      check("rr_bits_seq", 32'(mb_rr), 32'(8'h10 + (j - 1) % 4));
    end

    // Burst lock on ch1 (round-robin pointer now at 1) with ch2 competing.
    tick(); req_valid = 4'b0110; req_last = 4'b0100; req_bits = 32'h00B0A000; #3;
    check("burst_b0_rdy_rr", 32'(rdy_rr), 32'h2);
    check("burst_b0_rdy_fp", 32'(rdy_fp), 32'h4);
    tick(); req_bits = 32'h00B0A100; #3;
    check("burst_b1_rdy_rr", 32'(rdy_rr), 32'h2);
    check("burst_b1_bits_rr", 32'(mb_rr), 32'hA0);
    check("burst_b1_last_rr", 32'(ml_rr), 32'd0);
    tick(); req_valid = 4'b0100; #3;
    check("burst_bubble_rdy_rr", 32'(rdy_rr), 32'h0);
    tick(); req_valid = 4'b0110; req_last = 4'b0110; req_bits = 32'h00B0A200; #3;
    check("burst_b2_rdy_rr", 32'(rdy_rr), 32'h2);
    tick(); #3;
    check("burst_after_rdy_rr", 32'(rdy_rr), 32'h4);
    check("burst_after_bits_rr", 32'(mb_rr), 32'hA2);
    check("burst_after_last_rr", 32'(ml_rr), 32'd1);
    check("burst_after_chosen_rr", 32'(mc_rr), 32'd1);

    // Backpressure with ch0 valid.
    tick(); req_valid = '0; mem_ready = 1'b1;
    tick(); req_valid = 4'b0001; req_last = 4'b0001; req_bits = 32'h55; mem_ready = 1'b0; #3;
    check("bp_empty_mv_rr", 32'(mv_rr), 32'd0);
    check("bp_first_rdy_rr", 32'(rdy_rr), 32'h1);
    check("bp_first_rdy_fp", 32'(rdy_fp), 32'h1);
    for (int j = 0; j < 5; j++) begin
      tick(); req_bits = 32'h66; #3;
      check("bp_hold_rdy_rr", 32'(rdy_rr), 32'h0);
      check("bp_hold_rdy_fp", 32'(rdy_fp), 32'h0);
      check("bp_hold_mv_rr", 32'(mv_rr), 32'd1);
      check("bp_hold_bits_rr", 32'(mb_rr), 32'h55);
      check("bp_hold_bits_fp", 32'(mb_fp), 32'h55);
    end
    tick(); mem_ready = 1'b1; #3;
    check("bp_release_rdy_rr", 32'(rdy_rr), 32'h1);
    check("bp_release_bits_rr", 32'(mb_rr), 32'h55);
    tick(); #3;
    check("bp_replace_mv_rr", 32'(mv_rr), 32'd1);
    check("bp_replace_bits_rr", 32'(mb_rr), 32'h66);

    // Reset one cycle after ch2 opens a burst.
    tick(); req_valid = 4'b0100; req_last = 4'b0000; req_bits = 32'h00C00000; #3;
    check("rst_burst_rdy_rr", 32'(rdy_rr), 32'h4);
    tick(); reset = 1'b1; req_valid = 4'b0101; req_last = 4'b0001; req_bits = 32'h00C100D0; #3;
    check("rst_during_rdy_rr", 32'(rdy_rr), 32'h0);
    check("rst_during_rdy_fp", 32'(rdy_fp), 32'h0);
    check("rst_during_bits_rr", 32'(mb_rr), 32'hC0);
    tick(); reset = 1'b0; #3;
    check("rst_after_mv_rr", 32'(mv_rr), 32'd0);
    check("rst_after_mv_fp", 32'(mv_fp), 32'd0);
    check("rst_after_rdy_rr", 32'(rdy_rr), 32'h1);
    check("rst_after_rdy_fp", 32'(rdy_fp), 32'h4);
    tick(); #3;
    check("rst_after_chosen_rr", 32'(mc_rr), 32'd0);
    check("rst_after_bits_rr", 32'(mb_rr), 32'hD0);

    // Randomised traffic; the per-cycle compare process does the checking.
    for (int j = 0; j < 3000; j++) begin
      tick();
      reset     = ($urandom_range(0, 63) == 0);
      req_valid = N'($urandom);
      req_last  = N'($urandom);
      req_bits  = $urandom;
      mem_ready = ($urandom_range(0, 3) != 0);
    end

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
